// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite htrans/hsize encodings, slave FSM states and byte-strobe helpers
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'b000, HSIZE_HALF = 3'b001, HSIZE_WORD = 3'b010;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_t;
  function automatic logic [3:0] strb(input logic [2:0] size, input logic [1:0] a);
    return size == HSIZE_BYTE ? 4'b0001 << a : size == HSIZE_HALF ? 4'b0011 << {a[1], 1'b0} : 4'hF;
  endfunction
  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/sram_1rw.sv
// sram_1rw: synchronous single-port word memory (en/we/be/addr/wdata in, rdata out), byte enables, 1-cycle read latency
module sram_1rw #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] r_mem [2**AW];
  always_ff @(posedge clk) begin
    if (en && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (en && !we) rdata <= r_mem[addr];
  end
endmodule

// File: rtl/ahb_slave_rd.sv
// ahb_slave_rd: AHB-Lite data-memory slave (AHB bus in, hreadyout/hresp + right-justified read_data/load_hsize/load_signed/rdata_valid out); AHB_MISALIGN_ERR_EN turns misaligned transfers into a two-cycle ERROR
module ahb_slave_rd import ahb_pkg::*; #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        hsigned,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] read_data,
  output logic [2:0]  load_hsize,
  output logic        load_signed,
  output logic        rdata_valid
);
  localparam int WW = ADDR_W - 2;
  state_t r_state, w_next;
  logic [2:0] r_cnt, r_size, w_size;
  logic [ADDR_W-1:0] r_addr;
  logic r_write, r_signed, r_bv;
  logic [3:0] r_strb, r_bstrb, w_src_strb;
  logic [WW-1:0] r_baddr, w_src_addr, w_addr;
  logic [31:0] r_bdata, r_bymask, r_bydata, w_src_data, w_sram_rdata, w_word, w_shift;
  logic w_acc, w_err, w_rd, w_wr_last, w_hit;
  logic [1:0] w_off;
  assign w_acc = hsel && htrans[1] && hreadyout;
  assign w_size = hsize > HSIZE_WORD ? HSIZE_WORD : hsize;
  assign w_off = w_size == HSIZE_BYTE ? haddr[1:0] : w_size == HSIZE_HALF ? {haddr[1], 1'b0} : 2'b00;
`ifdef AHB_MISALIGN_ERR_EN
  assign w_err = (w_size == HSIZE_HALF && haddr[0]) || (w_size == HSIZE_WORD && haddr[1:0] != 2'b00);
  assign hresp = r_state == ST_ERR1 || r_state == ST_ERR2;
`else
  assign w_err = 1'b0;
  assign hresp = 1'b0;
`endif
  assign w_rd = w_acc && !hwrite && !w_err;
  assign w_wr_last = r_state == ST_LAST && r_write;
  // a completing write takes the port unless a read issues that edge; then it parks in the buffer
  assign w_src_addr = w_wr_last ? r_addr[ADDR_W-1:2] : r_baddr;
  assign w_src_strb = w_wr_last ? r_strb : r_bstrb;
  assign w_src_data = w_wr_last ? hwdata : r_bdata;
  assign w_hit = (w_wr_last || r_bv) && w_src_addr == haddr[ADDR_W-1:2];
  assign w_addr = w_rd ? haddr[ADDR_W-1:2] : w_src_addr;
  sram_1rw #(.AW(WW)) u_sram (
    .clk(clk), .en(w_rd || w_wr_last || r_bv), .we(!w_rd), .be(w_src_strb),
    .addr(w_addr), .wdata(w_src_data), .rdata(w_sram_rdata)
  );
  always_comb begin
    w_next = r_state;
    if (r_state == ST_WAIT) w_next = r_cnt == 3'(WAIT_STATES) ? ST_LAST : ST_WAIT;
    else if (r_state == ST_ERR1) w_next = ST_ERR2;
    else w_next = !w_acc ? ST_IDLE : w_err ? ST_ERR1 : WAIT_STATES == 0 ? ST_LAST : ST_WAIT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_size <= '0;
      r_write <= 1'b0;
      r_signed <= 1'b0;
      r_bv <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_acc ? 3'd1 : r_state == ST_WAIT ? r_cnt + 3'd1 : r_cnt;
      if (w_acc) begin
        r_size <= hsize;
        r_write <= hwrite;
        r_signed <= hsigned;
      end
      r_bv <= w_rd && w_wr_last ? 1'b1 : w_rd ? r_bv : 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_addr <= {haddr[ADDR_W-1:2], w_off};
      r_strb <= strb(w_size, w_off);
    end
    if (w_rd && w_wr_last) begin
      r_baddr <= r_addr[ADDR_W-1:2];
      r_bdata <= hwdata;
      r_bstrb <= r_strb;
    end
    if (w_rd) begin
      r_bymask <= w_hit ? lane_mask(w_src_strb) : '0;
      r_bydata <= w_src_data;
    end
  end
  assign hreadyout = !(r_state == ST_WAIT || r_state == ST_ERR1);
  assign rdata_valid = r_state == ST_LAST && !r_write;
  assign w_word = (w_sram_rdata & ~r_bymask) | (r_bydata & r_bymask);
  assign w_shift = w_word >> {r_addr[1:0], 3'b000};
  assign read_data = !rdata_valid ? '0 : r_size == HSIZE_BYTE ? {24'b0, w_shift[7:0]} :
                     r_size == HSIZE_HALF ? {16'b0, w_shift[15:0]} : w_shift;
  assign load_hsize = r_size;
  assign load_signed = r_signed;
endmodule

// File: tb/tb_ahb_slave_rd.sv
// tb_ahb_slave_rd: scoreboard bench for ahb_slave_rd
module tb_ahb_slave_rd;
  localparam int WS = 1;
  logic clk = 0, rst_n = 0, hsel = 0, hwrite = 0, hsigned = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 0;
  logic hreadyout, hresp, rdata_valid, load_signed;
  logic [31:0] read_data;
  logic [2:0] load_hsize;
  typedef struct {logic [31:0] data; logic [2:0] size; logic sg; int acc;} exp_t;
  exp_t q[$];
  logic [31:0] mdl [0:1023];
  int n_chk = 0, n_err = 0, cyc = 0;
  ahb_slave_rd #(.ADDR_W(12), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hsigned(hsigned), .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp),
    .read_data(read_data), .load_hsize(load_hsize), .load_signed(load_signed), .rdata_valid(rdata_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int aoff(input logic [31:0] a, input logic [2:0] sz);
    return sz == 0 ? int'(a[1:0]) : sz == 1 ? int'(a[1]) * 2 : 0;
  endfunction
  function automatic int nbytes(input logic [2:0] sz);
    return sz == 0 ? 1 : sz == 1 ? 2 : 4;
  endfunction
  always @(negedge clk) if (rst_n && rdata_valid) begin
    exp_t e;
    if (q.size() == 0) chk("spurious_valid", 1, 0);
    else begin
      e = q.pop_front();
      chk("rdata", read_data, e.data);
      chk("load_hsize", 32'(load_hsize), 32'(e.size));
      chk("load_signed", 32'(load_signed), 32'(e.sg));
      chk("latency", cyc - e.acc, WS);
    end
  end
  task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] sz, input bit sg, input logic [31:0] wd);
    int n = 0, o = aoff(a, sz), nb = nbytes(sz);
    bit rdy;
    logic [31:0] v;
    hsel = 1; htrans = 2'b10; hwrite = w; haddr = a; hsize = sz; hsigned = sg;
    do begin @(negedge clk); rdy = hreadyout; @(posedge clk); #1; n++; end while (!rdy && n < 50);
    if (!rdy) chk("accept_timeout", 0, 1);
    if (w) for (int b = o; b < o + nb; b++) mdl[a[11:2]][8*b +: 8] = wd[8*b +: 8];
    else begin
      v = mdl[a[11:2]] >> (8 * o);
      if (nb < 4) v = v & ((32'd1 << (8 * nb)) - 32'd1);
      q.push_back('{data: v, size: sz, sg: sg, acc: cyc});
    end
    hwdata = wd;
  endtask
  task automatic idle(input int n);
    int k = 0;
    bit rdy;
    hsel = 0; htrans = 0;
    do begin @(negedge clk); rdy = hreadyout; @(posedge clk); #1; k++; end while (!rdy && k < 50);
    if (!rdy) chk("idle_timeout", 0, 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    logic [31:0] a;
    logic [2:0] sz;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hreadyout", 32'(hreadyout), 1);
    chk("rst_hresp", 32'(hresp), 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_load_hsize", 32'(load_hsize), 0);
    chk("rst_load_signed", 32'(load_signed), 0);
    chk("rst_rdata_valid", 32'(rdata_valid), 0);
    @(posedge clk); #1 rst_n = 1;
    issue(1, 32'h10, 2, 0, 32'hDEADBEEF);
    issue(0, 32'h10, 2, 0, 0);
    issue(0, 32'h13, 0, 1, 0);
    issue(1, 32'h12, 1, 0, 32'h12340000);
    issue(0, 32'h10, 2, 0, 0);
    idle(2);
    issue(0, 32'h10, 2, 0, 0);
    idle(1);
    hsel = 1; htrans = 2'b01; hwrite = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_hreadyout", 32'(hreadyout), 1);
      chk("busy_hresp", 32'(hresp), 0);
      chk("busy_valid", 32'(rdata_valid), 0);
      @(posedge clk); #1;
    end
    issue(1, 32'h20, 2, 0, 32'hA5A5A5A5);
    idle(1);
    hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h20; hsize = 2; hsigned = 0;
    @(posedge clk); #1;
    hsel = 0; htrans = 0; hwdata = 32'h55; rst_n = 0;
    @(posedge clk); #1;
    chk("midrst_hreadyout", 32'(hreadyout), 1);
    chk("midrst_hresp", 32'(hresp), 0);
    chk("midrst_read_data", read_data, 0);
    chk("midrst_load_hsize", 32'(load_hsize), 0);
    chk("midrst_load_signed", 32'(load_signed), 0);
    chk("midrst_valid", 32'(rdata_valid), 0);
    rst_n = 1;
    issue(0, 32'h20, 2, 0, 0);
    idle(1);
    issue(1, 32'h0, 2, 0, 32'hCAFEF00D);
    idle(0);
`ifdef AHB_MISALIGN_ERR_EN
    hsel = 1; htrans = 2'b10; hwrite = 0; haddr = 32'h1; hsize = 1; hsigned = 0;
    @(posedge clk); #1;
    hsel = 0; htrans = 0;
    @(negedge clk);
    chk("err1_hreadyout", 32'(hreadyout), 0);
    chk("err1_hresp", 32'(hresp), 1);
    chk("err1_valid", 32'(rdata_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err2_hreadyout", 32'(hreadyout), 1);
    chk("err2_hresp", 32'(hresp), 1);
    chk("err2_valid", 32'(rdata_valid), 0);
    @(posedge clk); #1;
`else
    issue(0, 32'h1, 1, 0, 0);
    hsel = 0; htrans = 0;
    @(negedge clk);
    chk("mis_hresp", 32'(hresp), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_hresp_last", 32'(hresp), 0);
    @(posedge clk); #1;
`endif
    idle(1);
    for (int i = 0; i < 8; i++) issue(1, 32'h40 + 32'(4 * i), 2, 0, $urandom);
    for (int i = 0; i < 40; i++) begin
      a = 32'h40 + 32'($urandom_range(0, 31));
      sz = 3'($urandom_range(0, 2));
      a = sz == 1 ? a & ~32'd1 : sz == 2 ? a & ~32'd3 : a;
      issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
    end
    idle(3);
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ahb_slave_rd.md
# ahb_slave_rd

AHB-Lite data-memory slave that sits directly upstream of the load extension stage. Handles address/data phase pipelining, programmable wait states, byte-lane writes, and right-justification of read data. Presents each completed read to the extension stage as an unextended, LSB-aligned word with its registered size and signedness. All address-phase qualifiers are registered and travel with the data.

## Interface
- ADDR_W, 12: byte-address bits decoded; memory holds 2**(ADDR_W-2) words
- WAIT_STATES, 1: wait cycles inserted per accepted transfer (0..7)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- hsel  in  1  slave select
- haddr  in  32  byte address (bits ADDR_W-1:0 used)
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1=write
- hsize  in  3  000 byte, 001 half, 010 word; >010 treated as word
- hsigned  in  1  core sideband, load is signed; address phase
- hwdata  in  32  write data, lane-placed, data phase
- hreadyout  out  1  data phase complete
- hresp  out  1  0=OKAY, 1=ERROR
- read_data  out  32  right-justified, upper bits zero beyond size
- load_hsize  out  3  registered hsize of completing read
- load_signed  out  1  registered hsigned of completing read
- rdata_valid  out  1  one-cycle pulse, read_data/load_* valid

## Operation
- Accept: hsel && htrans[1] && hreadyout. IDLE/BUSY get zero-wait OKAY, no state change.
- On accept: register addr, size, write, signed; issue word read to SRAM at addr[ADDR_W-1:2].
- FSM IDLE -> WAIT (count WAIT_STATES) -> LAST -> IDLE, or LAST -> WAIT/LAST if a new transfer is accepted in LAST. WAIT_STATES=0 goes IDLE -> LAST directly.
- Byte strobes: byte 1<<a[1:0]; half 2'b11<<{a[1],1'b0}; word 4'hF.
- Write: hwdata sampled in LAST; strobed lanes written at that edge.
- Read: in LAST, read_data = (word >> 8*a[1:0]) masked to 8/16/32 bits; rdata_valid=1; load_hsize/load_signed driven from registered phase.
- Read-after-write bypass: a read accepted in the LAST cycle of a write to the same word merges the strobed write lanes into the returned word.
- Misaligned (half a[0]=1, word a[1:0]!=0) without the macro: low bits forced aligned down, OKAY.
- Memory contents are not reset.

## Timing
- Reset values: hreadyout=1, hresp=0, read_data=0, load_hsize=0, load_signed=0, rdata_valid=0, FSM=IDLE.
- Accept at cycle T: hreadyout=0 for T+1..T+WAIT_STATES; LAST at T+WAIT_STATES+1 with hreadyout=1.
- Read result valid in LAST only; the downstream extension stage registers it one cycle later.
- Back-to-back: a transfer accepted in LAST incurs no idle bubble.
- rst_n low mid-transfer: pending write dropped, outputs return to reset values next edge.

## Configuration
- AHB_MISALIGN_ERR_EN defined: misaligned transfers produce a two-cycle ERROR: cycle 1 hreadyout=0, hresp=1; cycle 2 hreadyout=1, hresp=1. No write occurs, rdata_valid stays 0, WAIT_STATES ignored.
- Undefined: alignment is forced down as above, hresp is tied to 0.

## Structure
- Shared ahb_pkg: htrans and hsize encodings, FSM state enum, strobe-generation function.
- One sub-module: sram_1rw, a synchronous one-port word memory with 4-bit byte enables and 1-cycle read latency.

## Test plan
- Word write 0xDEADBEEF @0x010, read word @0x010, WAIT_STATES=1 -> LAST at T+2, read_data=0xDEADBEEF, rdata_valid pulse.
- Signed byte read @0x013 after above, hsigned=1 -> read_data=0x000000DE, load_hsize=000, load_signed=1.
- Half write 0x1234 @0x012, then immediate back-to-back read word @0x010 -> bypass gives 0x1234BEEF.
- htrans=BUSY with hsel=1 -> hreadyout stays 1, hresp=0, no rdata_valid.
- rst_n low during WAIT of a write 0x55 @0x020 -> outputs at reset values, later read of @0x020 shows old contents.
- With AHB_MISALIGN_ERR_EN, half read @0x001 -> hresp=1 for 2 cycles (hreadyout 0 then 1), rdata_valid=0; without the macro -> OKAY, data from @0x000.
